// File: rtl/encoder_8to3_seq.sv
// rtl/encoder_8to3_seq.sv - sequential 8-to-3 priority encoder streaming set-bit indices, optional ENC_POPCOUNT_EN remaining-count output
module encoder_8to3_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       LOAD,
  input  logic [7:0] D,
  input  logic       READY,
  output logic [2:0] Y,
  output logic       VALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       NONE
`ifdef ENC_POPCOUNT_EN
  ,
  output logic [3:0] CNT
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] y_q, y_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       none_q, none_d;
  logic [7:0] pend_cleared;

`ifdef ENC_POPCOUNT_EN
  logic [3:0] cnt_q, cnt_d;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction
`endif

  // Index of the most-significant set bit; 0 for an all-zero vector.
  function automatic logic [2:0] msb_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Pending vector with the bit currently presented on Y removed.
  assign pend_cleared = pend_q & ~(8'b0000_0001 << y_q);

  // Next-state and registered-output decode; EN gating lives in the state register.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    y_d     = y_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    none_d  = 1'b0;
`ifdef ENC_POPCOUNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (LOAD) begin
          if (D != 8'h00) begin
            state_d = ST_EMIT;
            pend_d  = D;
            y_d     = msb_index(D);
            valid_d = 1'b1;
            busy_d  = 1'b1;
`ifdef ENC_POPCOUNT_EN
            cnt_d   = popcount8(D);
`endif
          end else begin
            none_d = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (READY) begin
          pend_d = pend_cleared;
`ifdef ENC_POPCOUNT_EN
          cnt_d  = cnt_q - 4'd1;
`endif
          if (pend_cleared == 8'h00) begin
            state_d = ST_IDLE;
            y_d     = 3'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            y_d = msb_index(pend_cleared);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 8'h00;
        y_d     = 3'd0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; everything freezes while EN is low, pulses included.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pend_q  <= 8'h00;
      y_q     <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      none_q  <= 1'b0;
`ifdef ENC_POPCOUNT_EN
      cnt_q   <= 4'd0;
`endif
    end else if (EN) begin
      state_q <= state_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      none_q  <= none_d;
`ifdef ENC_POPCOUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign Y     = y_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign NONE  = none_q;
`ifdef ENC_POPCOUNT_EN
  assign CNT   = cnt_q;
`endif

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb/tb_encoder_8to3_seq.sv - scoreboard bench for encoder_8to3_seq
module tb_encoder_8to3_seq;

  logic       CLK, RST, EN, LOAD, READY;
  logic [7:0] D;
  logic [2:0] Y;
  logic       VALID, BUSY, DONE, NONE;
`ifdef ENC_POPCOUNT_EN
  logic [3:0] CNT;
`endif

  encoder_8to3_seq dut (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .D(D), .READY(READY),
    .Y(Y), .VALID(VALID), .BUSY(BUSY), .DONE(DONE), .NONE(NONE)
`ifdef ENC_POPCOUNT_EN
    , .CNT(CNT)
`endif
  );

  typedef struct {
    logic [2:0] y;
    logic       last;
    logic [7:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int ones(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: indices of set bits, highest first; the lowest one closes the vector.
  task automatic push_vec(input logic [7:0] d);
    exp_t e;
    int   remaining;
    remaining = ones(d);
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) begin
        remaining--;
        e.y    = 3'(i);
        e.last = (remaining == 0);
        e.d    = d;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic load_vec(input logic [7:0] d);
    EN = 1'b1; LOAD = 1'b1; D = d;
    tick();
    LOAD = 1'b0;
    if (d == 8'h00) begin
      chk("none_pulse", NONE, 1);
      chk("none_valid", VALID, 0);
      chk("none_busy", BUSY, 0);
    end else begin
      push_vec(d);
      chk("load_valid", VALID, 1);
    end
  endtask

  task automatic run_stream(input bit randomize);
    int cyc = 0;
    while (BUSY && cyc < 400) begin
      if (randomize) begin
        READY = ($urandom_range(0, 3) != 0);
        EN    = ($urandom_range(0, 4) != 0);
        LOAD  = ($urandom_range(0, 3) == 0);
        D     = 8'($urandom);
      end else begin
        READY = 1'b1; EN = 1'b1; LOAD = 1'b0;
      end
      tick();
      cyc++;
    end
    if (BUSY) chk("stream_timeout", 1, 0);
    EN = 1'b1; READY = 1'b0; LOAD = 1'b0;
    tick();
  endtask

  // Monitor: compares presented Y against the scoreboard, pops on handshakes,
  // rebuilds each vector from the observed indices and tracks DONE timing.
  logic [7:0] acc;
  int         hs;
  bit         exp_done, prev_hold;
  logic [2:0] prev_y;
  always @(negedge CLK) begin
    exp_t e;
    bit   closed;
    closed = 0;
    if (!mon_en) begin
      acc = 8'h00; hs = 0; exp_done = 0; prev_hold = 0;
    end else begin
      chk("done", DONE, exp_done);
      chk("busy_eq_valid", BUSY, VALID);
      if (prev_hold) begin
        chk("hold_y", Y, prev_y);
        chk("hold_valid", VALID, 1);
      end
`ifdef ENC_POPCOUNT_EN
      begin
        int left = 0;
        if (VALID) begin
          foreach (sb_q[k]) begin
            left++;
            if (sb_q[k].last) break;
          end
        end
        chk("cnt", CNT, left);
      end
`endif
      if (VALID) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("y", Y, sb_q[0].y);
          if (READY && EN) begin
            e = sb_q.pop_front();
            acc = acc | (8'h01 << Y);
            hs++;
            if (e.last) begin
              chk("roundtrip_or", acc, e.d);
              chk("roundtrip_count", hs, ones(e.d));
              acc = 8'h00; hs = 0; closed = 1;
            end
          end
        end
      end
      if (EN) exp_done = closed;
      prev_hold = VALID && !(READY && EN);
      prev_y    = Y;
    end
  end

  int a5_exp[4] = '{7, 5, 2, 0};

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0; READY = 1'b0; D = 8'h00;
    #12;
    chk("rst_y", Y, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_none", NONE, 0);
    tick();
    RST = 1'b0; EN = 1'b1;
    mon_en = 1;
    tick();

    // Zero vector.
    load_vec(8'h00);
    tick();
    chk("none_one_cycle", NONE, 0);
    chk("none_valid_after", VALID, 0);

    // Full stream 0xA5.
    load_vec(8'hA5);
    READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("a5_y", Y, a5_exp[k]);
      tick();
    end
    chk("a5_done", DONE, 1);
    chk("a5_busy_end", BUSY, 0);
    READY = 1'b0;
    tick();
    chk("a5_done_width", DONE, 0);

    // Backpressure on 0x81.
    load_vec(8'h81);
    READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_y", Y, 7);
      chk("bp_valid", VALID, 1);
      tick();
    end
    READY = 1'b1;
    chk("bp_y_release", Y, 7);
    tick();
    chk("bp_y_next", Y, 0);
    tick();
    chk("bp_done", DONE, 1);
    READY = 1'b0;
    tick();

    // Enable freeze with competing load.
    load_vec(8'hC3);
    READY = 1'b1;
    tick();
    chk("frz_y_before", Y, 6);
    EN = 1'b0; LOAD = 1'b1; D = 8'h01;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_y", Y, 6);
      chk("frz_valid", VALID, 1);
    end
    EN = 1'b1; LOAD = 1'b0;
    tick();
    chk("frz_resume_y1", Y, 1);
    tick();
    chk("frz_resume_y0", Y, 0);
    tick();
    chk("frz_done", DONE, 1);
    READY = 1'b0;
    tick();

    // Asynchronous reset mid-stream.
    load_vec(8'hFF);
    READY = 1'b1;
    tick();
    tick();
    mon_en = 0;
    READY = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("arst_valid", VALID, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_y", Y, 0);
    sb_q.delete();
    tick();
    RST = 1'b0;
    tick();
    mon_en = 1;
    load_vec(8'h10);
    chk("arst_reload_y", Y, 4);
    run_stream(0);

    // Round trip over every vector with randomized handshake, enable and stray loads.
    for (int v = 0; v < 256; v++) begin
      load_vec(8'(v));
      run_stream(1);
    end
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_8to3_seq.md
# encoder_8to3_seq

Sequential 8-to-3 priority encoder, the inverse of the team's 3-to-8 decoder. It captures an 8-bit multi-hot vector and emits the 3-bit index of every set bit, highest index first, one index per valid/ready handshake. It sits between request-generating logic and any consumer that needs binary indices. Its output indices can be fed back through the 3-to-8 decoder to rebuild the original vector.

## Interface
- Parameters: none. Width is fixed at 8 in, 3 out.
- `CLK` in 1: rising-edge clock.
- `RST` in 1: asynchronous, active-high reset.
- `EN` in 1: global enable. When 0, all state is frozen.
- `LOAD` in 1: capture request. Sampled only in IDLE.
- `D` in 8: request vector. Bit n requests index n.
- `READY` in 1: consumer accepts the current `Y`.
- `Y` out 3: index of the highest pending bit.
- `VALID` out 1: `Y` holds a valid index.
- `BUSY` out 1: the FSM is in EMIT.
- `DONE` out 1: one-cycle pulse after the last index is accepted.
- `NONE` out 1: one-cycle pulse when a load captures `D == 8'h00`.

## Operation
- Internal 8-bit pending register `PEND`. FSM states: IDLE, EMIT.
- Reset: `PEND=0`, state=IDLE, `Y=3'b000`, `VALID=0`, `BUSY=0`, `DONE=0`, `NONE=0`.
- IDLE with `EN & LOAD`:
  - If `D != 0`: `PEND <= D`, go to EMIT.
  - If `D == 0`: pulse `NONE`, stay in IDLE.
- EMIT outputs:
  - `VALID=1`, `BUSY=1`.
  - `Y` = index of the most-significant set bit of `PEND`.
- EMIT handshake: on `EN & READY`, clear bit `Y` of `PEND`.
  - If the result is 0: go to IDLE and pulse `DONE` in the next cycle.
  - Otherwise: stay in EMIT; `Y` shows the next index in the following cycle.
- `LOAD` is ignored while in EMIT. No queueing.
- `READY` low in EMIT: `Y` and `VALID` hold steady (standard valid/ready; `VALID` never drops without a handshake).
- `EN` low: `PEND`, state and outputs hold. `DONE` and `NONE` do not fire. Handshakes are not taken even if `READY=1`.
- `RST` mid-EMIT: outputs return to reset values immediately (asynchronous). Pending bits are discarded.
- `Y`, `VALID`, `BUSY`, `DONE` and `NONE` are decoded from registers only. There is no combinational path from `D`, `LOAD` or `READY` to any output.

## Timing
- Load latency:
  - `LOAD` sampled at edge k: `VALID=1` from edge k to edge k+1.
  - `NONE` asserts over the same window for a zero vector.
- Throughput: one index per cycle while `READY=1`.
  - A vector with N set bits emits in N cycles.
  - `DONE` is high in cycle N+1 after the first `VALID` cycle.
- `DONE` and `NONE` are exactly one cycle wide when `EN=1`.
- A new `LOAD` is accepted in the cycle `DONE` is high (FSM already in IDLE), giving back-to-back vectors with a one-cycle gap.
- `RST` deasserting: first active edge after deassertion sees IDLE.

## Configuration
- Macro `ENC_POPCOUNT_EN`.
- Defined:
  - Adds output `CNT` out 4.
  - `CNT` = number of set bits remaining in `PEND` (reset 0).
  - `CNT` equals popcount(`D`) the cycle after load and decrements by 1 per handshake.
  - `CNT` is 0 in IDLE.
- Undefined: no `CNT` port, no popcount logic.
- All other behaviour is identical in both builds.

## Test plan
- Reset mid-operation:
  - Stimulus: load `8'hFF`, take two handshakes, assert `RST`.
  - Required: `VALID`/`BUSY`/`Y` drop to 0 without waiting for a clock edge.
  - After release, IDLE accepts a new load.
- Zero vector:
  - Stimulus: `LOAD` with `D=8'h00`.
  - Required: `NONE=1` for one cycle, `VALID` stays 0, `BUSY` stays 0.
- Full stream:
  - Stimulus: `D=8'hA5`, `READY=1`.
  - Required: `Y` = 7, 5, 2, 0 on consecutive cycles, then `DONE` for one cycle.
  - With `ENC_POPCOUNT_EN`: `CNT` = 4, 3, 2, 1, then 0.
- Backpressure:
  - Stimulus: `D=8'h81`, `READY` low for 3 cycles.
  - Required: `Y=7` stable with `VALID=1` throughout.
  - `READY` high then yields `Y=0`, then `DONE`.
- Enable freeze and load blocking:
  - Stimulus: drop `EN` mid-EMIT with `READY=1` and `LOAD=1`, `D=8'h01`.
  - Required: no index advances and the new vector is not captured.
  - On restoring `EN`: the stream resumes from the held `Y`.
- Round trip:
  - Stimulus: loop over all 256 `D` values.
  - Required: OR of decoder(`Y`) across all handshakes equals `D`.
  - Required: handshake count equals popcount(`D`).
